axi_dma_rd_mb: RTL and testbench

AXI_DMA_RD_MB -- requirements
Module: axi_dma_rd_mb

---
 rtl/axi_dma_rd_mb_if.sv | 42 ++++
 rtl/axi_dma_rd_mb.sv | 213 +++++++++++++++++++++
 tb/tb_axi_dma_rd_mb.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_rd_mb_if.sv
// AXI4 read-address / read-data channel bundle for axi_dma_rd_mb.
// master = DMA side (drives AR, accepts R); slave = memory side.
interface axi_dma_rd_mb_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 30,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]   m_axi_arid;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arlock;
    logic [3:0]        m_axi_arcache;
    logic [2:0]        m_axi_arprot;
    logic [3:0]        m_axi_arqos;
    logic              m_axi_arvalid;
    logic              m_axi_arready;

    logic [ID_W-1:0]   m_axi_rid;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
               m_axi_rready,
        input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_rvalid
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
               m_axi_rready,
        output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_rvalid
    );
endinterface

// File: rtl/axi_dma_rd_mb.sv
// Multi-burst AXI4 read DMA: splits an nbeats transfer into INCR bursts and streams R data out.
// Optional macro AXI_DMA_4K_SPLIT_EN additionally stops bursts at 4 KB boundaries.
module axi_dma_rd_mb #(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 30,
    parameter int XFER_W    = 20,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [XFER_W-1:0] nbeats,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    axi_dma_rd_mb_if.master   axi
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int CW    = (XFER_W > 13) ? XFER_W : 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic [XFER_W-1:0] left_r;
    logic [XFER_W-1:0] left_nxt_s;
    logic [8:0]        burst_r;
    logic [8:0]        burst_nxt_s;
    logic [8:0]        beat_cnt_r;
    logic [CW-1:0]     lim4k_s;
    logic              arvalid_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;
    logic              accept_s;
    logic              zero_s;
    logic              ar_fire_s;
    logic              beat_fire_s;
    logic              burst_end_s;
    logic              last_in_burst_s;
    logic              final_burst_s;
    logic              beat_bad_s;
    logic              in_data_s;
    logic              unused_s;

    // Burst size is the smallest of beats remaining, MAX_BURST and the boundary limit.
    function automatic logic [8:0] min_burst(input logic [CW-1:0] left,
                                             input logic [CW-1:0] lim4k);
        logic [CW-1:0] lim;
        lim = (lim4k < CW'(MAX_BURST)) ? lim4k : CW'(MAX_BURST);
        return (left < lim) ? left[8:0] : lim[8:0];
    endfunction

    assign axi.m_axi_arid    = '0;
    assign axi.m_axi_arsize  = 3'(OFFS);
    assign axi.m_axi_arburst = 2'b01;
    assign axi.m_axi_arlock  = 1'b0;
    assign axi.m_axi_arcache = 4'h2;
    assign axi.m_axi_arprot  = 3'b010;
    assign axi.m_axi_arqos   = 4'h0;
    assign axi.m_axi_araddr  = addr_r;
    assign axi.m_axi_arlen   = 8'(burst_r - 9'd1);
    assign axi.m_axi_arvalid = arvalid_r;

    // Stream side is a pass-through of R while in DATA; forced quiet during reset.
    assign in_data_s         = (state_r == DATA) && !rst;
    assign axi.m_axi_rready  = in_data_s && out_ready;
    assign out_valid         = in_data_s && axi.m_axi_rvalid;
    assign out_data          = axi.m_axi_rdata;
    assign out_last          = out_valid && last_in_burst_s && final_burst_s;

    assign busy  = busy_r;
    assign done  = done_r;
    assign error = error_r;

    assign unused_s = ^{1'b0, axi.m_axi_rid};

    assign last_in_burst_s = (beat_cnt_r == (burst_r - 9'd1));
    assign final_burst_s   = (CW'(left_r) == CW'(burst_r));
    assign beat_bad_s      = (axi.m_axi_rresp != 2'b00) ||
                             (axi.m_axi_rlast != last_in_burst_s);

    // Next-state and handshake strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        zero_s      = 1'b0;
        ar_fire_s   = 1'b0;
        beat_fire_s = 1'b0;
        burst_end_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (nbeats != {XFER_W{1'b0}})) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ADDR;
                end else if (start) begin
                    zero_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADDR: begin
                if (axi.m_axi_arready) begin
                    ar_fire_s   = 1'b1;
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = ADDR;
                end
            end
            DATA: begin
                if (axi.m_axi_rvalid && out_ready) begin
                    beat_fire_s = 1'b1;
                    if (last_in_burst_s) begin
                        burst_end_s = 1'b1;
                        state_nxt_s = final_burst_s ? IDLE : ADDR;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Address/length bookkeeping: latch on accept, advance when a burst completes.
    always_comb begin
        addr_nxt_s = addr_r;
        left_nxt_s = left_r;
        if (accept_s) begin
            addr_nxt_s = {base_addr[ADDR_W-1:OFFS], {OFFS{1'b0}}};
            left_nxt_s = nbeats;
        end else if (burst_end_s) begin
            addr_nxt_s = addr_r + (ADDR_W'(burst_r) << OFFS);
            left_nxt_s = left_r - XFER_W'(burst_r);
        end else begin
            addr_nxt_s = addr_r;
            left_nxt_s = left_r;
        end
    end

    // Beats left before the next 4 KB boundary, or no extra limit when splitting is off.
    always_comb begin
`ifdef AXI_DMA_4K_SPLIT_EN
        lim4k_s = CW'((13'd4096 - {1'b0, addr_nxt_s[11:0]}) >> OFFS);
`else
        lim4k_s = CW'(MAX_BURST);
`endif
        burst_nxt_s = min_burst(CW'(left_nxt_s), lim4k_s);
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            left_r     <= '0;
            burst_r    <= 9'd0;
            beat_cnt_r <= 9'd0;
            arvalid_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            addr_r    <= addr_nxt_s;
            left_r    <= left_nxt_s;
            arvalid_r <= (state_nxt_s == ADDR);
            done_r    <= zero_s || (burst_end_s && final_burst_s);
            // Burst size is frozen on entry to ADDR so arlen stays stable until accepted.
            if ((state_nxt_s == ADDR) && (state_r != ADDR)) begin
                burst_r <= burst_nxt_s;
            end else begin
                burst_r <= burst_r;
            end
            if (ar_fire_s) begin
                beat_cnt_r <= 9'd0;
            end else if (beat_fire_s) begin
                beat_cnt_r <= beat_cnt_r + 9'd1;
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (state_nxt_s == IDLE) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            // Error is sticky across the transfer; only a newly accepted transfer clears it.
            if (accept_s) begin
                error_r <= 1'b0;
            end else if (beat_fire_s && beat_bad_s) begin
                error_r <= 1'b1;
            end else begin
                error_r <= error_r;
            end
        end
    end
endmodule

// File: tb/tb_axi_dma_rd_mb.sv
// Scoreboard bench for axi_dma_rd_mb: AXI slave model with random arready delay and
// random out_ready; expected ARs and beats are queued at start and popped on handshakes.
module tb_axi_dma_rd_mb;
    localparam int DW = 256;
    localparam int AW = 30;
    localparam int XW = 20;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [XW-1:0] nbeats;
    logic          busy, done, error;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] out_data;

    always #5 clk = ~clk;

    axi_dma_rd_mb_if #(.DATA_W(DW), .ADDR_W(AW)) axi ();

    axi_dma_rd_mb #(.DATA_W(DW), .ADDR_W(AW), .XFER_W(XW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .nbeats(nbeats),
        .busy(busy), .done(done), .error(error), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .axi(axi.master)
    );

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [DW-1:0] data; logic last; } beat_t;

    ar_t   exp_ar_q[$];
    ar_t   pend_q[$];
    beat_t exp_beat_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int ar_cnt   = 0;
    int g_beat   = 0;
    int err_beat = -1;
    int drop_beat = -1;
    bit rand_ready = 1'b0;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {2'b10, a};
        return {8{w}};
    endfunction

    // AXI slave model plus handshake monitors.
    initial begin : slave
        bit            ar_hs, r_hs, rst_seen, ar_wait, stab_pend, final_pend;
        logic [AW-1:0] ar_addr, stab_addr;
        logic [7:0]    ar_len, stab_len;
        int            r_idx, ar_dly;
        ar_t           t;
        beat_t         eb;
        logic [AW-1:0] a;
        r_idx = 0; ar_dly = 0; stab_pend = 0; final_pend = 0;
        axi.m_axi_arready = 1'b0; axi.m_axi_rvalid = 1'b0; axi.m_axi_rid = '0;
        axi.m_axi_rdata = '0; axi.m_axi_rresp = 2'b00; axi.m_axi_rlast = 1'b0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            rst_seen = rst;
            ar_hs    = !rst && axi.m_axi_arvalid && axi.m_axi_arready;
            ar_wait  = !rst && axi.m_axi_arvalid && !axi.m_axi_arready;
            r_hs     = !rst && axi.m_axi_rvalid && axi.m_axi_rready;
            ar_addr  = axi.m_axi_araddr;
            ar_len   = axi.m_axi_arlen;
            if (rst) begin
                stab_pend = 0;
                final_pend = 0;
            end else begin
                if (final_pend) check_eq("done_after_last", done, 1'b1);
                final_pend = r_hs && out_last;
                if (stab_pend) begin
                    check_eq("ar_valid_hold", axi.m_axi_arvalid, 1'b1);
                    check_eq("ar_addr_hold", axi.m_axi_araddr, stab_addr);
                    check_eq("ar_len_hold", axi.m_axi_arlen, stab_len);
                end
                stab_pend = ar_wait;
                stab_addr = ar_addr;
                stab_len  = ar_len;
                if (axi.m_axi_rvalid) begin
                    check_eq("rready_trk", axi.m_axi_rready, out_ready);
                    check_eq("out_valid", out_valid, 1'b1);
                end
                if (ar_hs) begin
                    ar_cnt++;
                    if (exp_ar_q.size() > 0) begin
                        t = exp_ar_q.pop_front();
                        check_eq("ar_addr", ar_addr, t.addr);
                        check_eq("ar_len", ar_len, t.len);
                    end else begin
                        check_eq("ar_unexpected", exp_ar_q.size(), 1);
                    end
                end
                if (r_hs) begin
                    if (exp_beat_q.size() > 0) begin
                        eb = exp_beat_q.pop_front();
                        check_eq("beat_data", out_data, eb.data);
                        check_eq("beat_last", out_last, eb.last);
                    end else begin
                        check_eq("beat_unexpected", exp_beat_q.size(), 1);
                    end
                end
                if (done) done_cnt++;
            end
            @(posedge clk);
            #1;
            if (rst_seen) begin
                pend_q.delete();
                r_idx = 0;
                axi.m_axi_arready = 1'b0;
            end else begin
                if (ar_hs) begin
                    t.addr = ar_addr;
                    t.len  = ar_len;
                    pend_q.push_back(t);
                    axi.m_axi_arready = 1'b0;
                    ar_dly = $urandom_range(0, 5);
                end else if (ar_wait) begin
                    if (ar_dly == 0) axi.m_axi_arready = 1'b1;
                    else ar_dly--;
                end
                if (r_hs) begin
                    g_beat++;
                    r_idx++;
                    if (r_idx > int'(pend_q[0].len)) begin
                        void'(pend_q.pop_front());
                        r_idx = 0;
                    end
                end
            end
            if (pend_q.size() > 0) begin
                a = pend_q[0].addr + AW'(r_idx * 32);
                axi.m_axi_rvalid = 1'b1;
                axi.m_axi_rdata  = pat(a);
                axi.m_axi_rlast  = (r_idx == int'(pend_q[0].len)) ^ (g_beat == drop_beat);
                axi.m_axi_rresp  = (g_beat == err_beat) ? 2'b10 : 2'b00;
            end else begin
                axi.m_axi_rvalid = 1'b0;
                axi.m_axi_rdata  = '0;
                axi.m_axi_rlast  = 1'b0;
                axi.m_axi_rresp  = 2'b00;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Queue the bursts and beats an independent burst-split model predicts.
    task automatic push_expect(input logic [AW-1:0] base, input int n, output int nar);
        logic [AW-1:0] a;
        int left, b, lim;
        ar_t t;
        beat_t e;
        a = base & ~30'h1F;
        left = n;
        nar = 0;
        while (left > 0) begin
            b = (left < MB) ? left : MB;
`ifdef AXI_DMA_4K_SPLIT_EN
            lim = (4096 - int'(a[11:0])) / 32;
            if (lim < b) b = lim;
`else
            lim = b;
`endif
            t.addr = a;
            t.len  = 8'(b - 1);
            exp_ar_q.push_back(t);
            for (int k = 0; k < b; k++) begin
                e.data = pat(a + AW'(k * 32));
                e.last = (left == b) && (k == b - 1);
                exp_beat_q.push_back(e);
            end
            a = a + AW'(b * 32);
            left -= b;
            nar++;
        end
    endtask

    task automatic run_xfer(input logic [AW-1:0] base, input int n, input bit exp_err,
                            input bit poke);
        int nar;
        push_expect(base, n, nar);
        @(posedge clk); #2;
        done_cnt = 0; ar_cnt = 0; g_beat = 0;
        base_addr = base; nbeats = XW'(n); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check_eq("busy_set", busy, 1'b1);
        check_eq("err_clr_on_start", error, 1'b0);
        if (poke) begin
            repeat (3) @(posedge clk);
            #2;
            base_addr = 30'h0001_2340; nbeats = XW'(5); start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
        end
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            @(posedge clk); #2;
        end
        check_eq("done_seen", done_cnt, 1);
        repeat (3) @(posedge clk);
        #2;
        check_eq("done_once", done_cnt, 1);
        check_eq("busy_clr", busy, 1'b0);
        check_eq("error_end", error, exp_err);
        check_eq("ar_count", ar_cnt, nar);
        check_eq("ar_q_left", exp_ar_q.size(), 0);
        check_eq("beat_q_left", exp_beat_q.size(), 0);
    endtask

    initial begin : main
        int nar;
        rst = 1'b1; start = 1'b0; base_addr = '0; nbeats = '0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_error", error, 1'b0);
        check_eq("rst_arvalid", axi.m_axi_arvalid, 1'b0);
        check_eq("rst_rready", axi.m_axi_rready, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_last", out_last, 1'b0);
        check_eq("arsize", axi.m_axi_arsize, 3'd5);
        check_eq("arburst", axi.m_axi_arburst, 2'b01);
        check_eq("arcache", axi.m_axi_arcache, 4'h2);
        check_eq("arprot", axi.m_axi_arprot, 3'b010);
        check_eq("arid_lock_qos", {axi.m_axi_arid, axi.m_axi_arlock, axi.m_axi_arqos}, 0);
        rst = 1'b0;

        run_xfer(30'h0, 40, 1'b0, 1'b0);
        run_xfer(30'hF80, 8, 1'b0, 1'b0);
        rand_ready = 1'b1;
        run_xfer(30'h0001_2F40, 37, 1'b0, 1'b0);
        rand_ready = 1'b0;

        err_beat = 4;
        run_xfer(30'h4000, 16, 1'b1, 1'b0);
        err_beat = -1;
        drop_beat = 15;
        run_xfer(30'h8000, 16, 1'b1, 1'b0);
        drop_beat = -1;

        // Zero-length request: done next cycle, no AR, error left alone.
        @(posedge clk); #2;
        done_cnt = 0; ar_cnt = 0;
        base_addr = 30'h100; nbeats = '0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check_eq("zero_done", done, 1'b1);
        check_eq("zero_busy", busy, 1'b0);
        check_eq("zero_arvalid", axi.m_axi_arvalid, 1'b0);
        @(posedge clk); #2;
        check_eq("zero_done_pulse", done, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check_eq("zero_ar_count", ar_cnt, 0);
        check_eq("zero_done_cnt", done_cnt, 1);
        check_eq("zero_err_keep", error, 1'b1);

        run_xfer(30'h9000, 5, 1'b0, 1'b0);
        run_xfer(30'hA000, 20, 1'b0, 1'b1);

        // Reset while the 7th beat of a burst is on the bus.
        err_beat = 1;
        push_expect(30'hB000, 16, nar);
        @(posedge clk); #2;
        g_beat = 0;
        base_addr = 30'hB000; nbeats = XW'(16); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int i = 0; i < 500 && g_beat < 6; i++) begin
            @(posedge clk); #2;
        end
        check_eq("pre_rst_beats", g_beat, 6);
        check_eq("pre_rst_error", error, 1'b1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_arvalid", axi.m_axi_arvalid, 1'b0);
        check_eq("mid_rst_rready", axi.m_axi_rready, 1'b0);
        check_eq("mid_rst_error", error, 1'b0);
        exp_ar_q.delete();
        exp_beat_q.delete();
        err_beat = -1;
        repeat (2) @(posedge clk);
        run_xfer(30'hC000, 24, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
